// File: rtl/reg_dump_engine.sv
// reg_dump_engine: while the CPU is halted, walks register-file read port 2 and streams each byte on a valid/ready channel.
// Optional feature macro REGDUMP_CHECKSUM_EN appends a running-XOR checksum byte after the last register.
module reg_dump_engine #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 8,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpu_halted,
    output logic [ADDR_W-1:0] rf_address,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FIRST_REG + NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                abort_q, abort_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q, csum_d;
    logic                csum_phase_q, csum_phase_d;
`endif

    // NOTE: every register is updated with <= so all of them see the pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            abort_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            abort_q      <= abort_d;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        abort_d      = abort_q;
`ifdef REGDUMP_CHECKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && cpu_halted) begin
                    addr_d       = FIRST_ADDR;
                    abort_d      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    csum_d       = '0;
                    csum_phase_d = 1'b0;
`endif
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!cpu_halted) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d  = rf_data;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // An abort here only marks the dump; the pending byte still completes its handshake.
                if (!cpu_halted) abort_d = 1'b1;
                if (out_ready) begin
`ifdef REGDUMP_CHECKSUM_EN
                    if (!csum_phase_q) csum_d = csum_q ^ data_q;
`endif
                    if (abort_d) begin
                        state_d = S_DONE;
`ifdef REGDUMP_CHECKSUM_EN
                    end else if (csum_phase_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = S_CSUM;
`else
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CSUM: begin
                // Loads the finished checksum and reuses SEND for its handshake.
                if (!cpu_halted) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d       = csum_q;
                    csum_phase_d = 1'b1;
                    state_d      = S_SEND;
                end
            end
`endif
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rf_address = addr_q;
    assign out_data   = data_q;
    assign out_valid  = (state_q == S_SEND);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign aborted    = (state_q == S_DONE) && abort_q;

endmodule

// File: tb/tb_reg_dump_engine.sv
// Scoreboard bench for reg_dump_engine: stimulus pushes expected bytes/done flags, a negedge monitor pops and compares.
// Define REGDUMP_CHECKSUM_EN for both RTL and bench to exercise the checksum byte.
module tb_reg_dump_engine;

    localparam int NUM_REGS = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int EXTRA_CYC  = 2;
    localparam int EXTRA_BYTE = 1;
`else
    localparam int EXTRA_CYC  = 0;
    localparam int EXTRA_BYTE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, cpu_halted;
    logic [4:0] rf_address;
    logic [7:0] rf_data, out_data;
    logic       out_valid, out_ready, busy, done, aborted;

    logic [7:0] regs [NUM_REGS];
    assign rf_data = regs[rf_address];

    reg_dump_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cpu_halted (cpu_halted),
        .rf_address (rf_address),
        .rf_data    (rf_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   ready_mode   = 0;
    logic manual_ready = 1'b1;
    assign out_ready = (ready_mode == 0) ? 1'b1 :
                       (ready_mode == 1) ? (cyc % 3 == 0) : manual_ready;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    bit         exp_abort_q[$];

    int         bytes_seen = 0;
    int         done_count = 0;
    int         done_edge  = 0;
    logic       hold_prev  = 1'b0;
    logic [7:0] data_prev  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: samples half a cycle after each edge; valid&&ready here means accept at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, data_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 1, 0);
                else check("byte", out_data, exp_q.pop_front());
                bytes_seen <= bytes_seen + 1;
            end
            if (done) begin
                if (exp_abort_q.size() == 0) check("extra_done", 1, 0);
                else check("aborted", aborted, exp_abort_q.pop_front());
                check("busy_in_done", busy, 0);
                done_count <= done_count + 1;
                done_edge  <= cyc + 1;
            end
            hold_prev <= out_valid && !out_ready;
            data_prev <= out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int k);
        start = 1'b1;
        tick();
        k = cyc;
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int i;
        for (i = 0; i < budget && bytes_seen < n; i++) tick();
        if (bytes_seen < n) check("timeout_bytes", bytes_seen, n);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_count;
        int i;
        for (i = 0; i < budget && done_count == d0; i++) tick();
        if (done_count == d0) check("timeout_done", 0, 1);
    endtask

    // Expected stream for a full dump of the current register contents.
    task automatic push_dump();
        logic [7:0] x = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back(regs[i]);
            x ^= regs[i];
        end
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_abort_q.push_back(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, b0, d0, busy_seen;

        rst = 1'b1; start = 1'b0; cpu_halted = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'(3 * i);
        repeat (3) tick();
        check("rst_rf_address", rf_address, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        rst = 1'b0;
        tick();

        // Test 1: full dump, sink always ready; bytes 0x00,0x03..0x5D.
        check("t1_last_reg_model", regs[31], 8'h5D);
        push_dump();
        do_start(k);
        tick();
        check("t1_busy", busy, 1);
        wait_done(200);
        check("t1_done_edge", done_edge - k, 65 + EXTRA_CYC);
        check("t1_queue_empty", exp_q.size(), 0);

        // Test 2: sink ready 1-of-3 cycles, plus a start pulse mid-dump that must be ignored.
        ready_mode = 1;
        b0 = bytes_seen;
        push_dump();
        do_start(k);
        wait_bytes(b0 + 8, 200);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(600);
        check("t2_byte_count", bytes_seen - b0, NUM_REGS + EXTRA_BYTE);
        check("t2_queue_empty", exp_q.size(), 0);
        ready_mode = 0;
        tick();

        // Test 3: start while CPU running is ignored.
        cpu_halted = 1'b0;
        d0 = done_count;
        b0 = bytes_seen;
        start = 1'b1; tick(); start = 1'b0;
        busy_seen = 0;
        repeat (10) begin
            tick();
            if (busy || out_valid || done) busy_seen++;
        end
        check("t3_stayed_idle", busy_seen, 0);
        check("t3_no_done", done_count - d0, 0);
        check("t3_no_bytes", bytes_seen - b0, 0);
        cpu_halted = 1'b1;

        // Test 4: halt drops while byte 5 is pending and the sink stalls two more cycles.
        ready_mode = 2; manual_ready = 1'b1;
        b0 = bytes_seen;
        for (int i = 0; i < 6; i++) exp_q.push_back(regs[i]);
        exp_abort_q.push_back(1'b1);
        do_start(k);
        wait_bytes(b0 + 5, 100);
        manual_ready = 1'b0;
        tick();
        check("t4_byte5_pending", out_valid, 1);
        cpu_halted = 1'b0;
        tick();
        tick();
        manual_ready = 1'b1;
        wait_done(20);
        check("t4_byte_count", bytes_seen - b0, 6);
        check("t4_queue_empty", exp_q.size(), 0);
        cpu_halted = 1'b1;
        ready_mode = 0;
        tick();

        // Test 5: reset at byte 10 kills the dump silently; a fresh dump then completes.
        push_dump();
        do_start(k);
        wait_bytes(bytes_seen + 10, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid_after_rst", out_valid, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_done_after_rst", done, 0);
        exp_q.delete();
        exp_abort_q.delete();
        d0 = done_count;
        repeat (4) tick();
        check("t5_no_done_pulse", done_count - d0, 0);
        b0 = bytes_seen;
        push_dump();
        do_start(k);
        wait_done(200);
        check("t5_redump_count", bytes_seen - b0, NUM_REGS + EXTRA_BYTE);
        check("t5_redump_edge", done_edge - k, 65 + EXTRA_CYC);
        check("t5_queue_empty", exp_q.size(), 0);

`ifdef REGDUMP_CHECKSUM_EN
        // Test 6: checksum byte with hand-computed values.
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = 8'(i);
            exp_q.push_back(8'(i));
        end
        exp_q.push_back(8'h00);
        exp_abort_q.push_back(1'b0);
        do_start(k);
        wait_done(200);
        check("t6_done_edge", done_edge - k, 67);
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = (i == 7) ? 8'hA5 : 8'h00;
            exp_q.push_back((i == 7) ? 8'hA5 : 8'h00);
        end
        exp_q.push_back(8'hA5);
        exp_abort_q.push_back(1'b0);
        do_start(k);
        wait_done(200);
        check("t6_queue_empty", exp_q.size(), 0);
`endif

        repeat (3) tick();
        check("final_abort_q_empty", exp_abort_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
